// File: rtl/bcd_line_buf.sv
// Print-line assembly behind the EBCDIC-to-BCD converter: aligns, buffers and scans out one line.
// Optional BCD_PARITY_EN macro: generates the odd-parity C bit on o_scan_parity.
module bcd_line_buf #(
  parameter int LINE_LEN = 132,
  parameter int CONV_LAT = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_strobe,
  input  logic [5:0] i_bcd,
  input  logic       i_space,
  input  logic       i_unassigned,
  input  logic       i_print,
  input  logic       i_clear,
  input  logic       i_scan_ready,
  output logic       o_scan_valid,
  output logic [7:0] o_scan_pos,
  output logic [5:0] o_scan_char,
  output logic       o_scan_parity,
  output logic       o_print_done,
  output logic [7:0] o_count,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_data_check,
  output logic       o_overrun
);

  typedef enum logic {ST_LOAD, ST_SCAN} state_t;

  localparam logic [7:0] LEN8  = 8'(LINE_LEN);
  localparam logic [7:0] LAST8 = 8'(LINE_LEN - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CONV_LAT-1:0] r_pipe;
  logic                r_pend;
  logic [7:0]          r_count;
  logic                r_dc;
  logic                r_ov;
  logic [5:0]          r_buf [LINE_LEN];
  logic                r_valid;
  logic [7:0]          r_pos;
  logic [5:0]          r_char;
  logic                r_done;

  logic                w_aligned;
  logic                w_pipe_empty;
  logic                w_load;
  logic                w_enter;
  logic                w_accept;
  logic                w_last;
  logic                w_busy;
  logic [7:0]          w_rd_pos;
  logic [5:0]          w_rd_char;
  logic [5:0]          w_wr_char;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_LOAD;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_clear) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (r_pend && w_pipe_empty) w_next = ST_SCAN;
        ST_SCAN: if (w_last) w_next = ST_LOAD;
        default: w_next = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    w_aligned    = r_pipe[CONV_LAT-1];
    w_pipe_empty = (r_pipe == '0);
    w_load       = w_aligned && (r_state == ST_LOAD) && (r_count != LEN8);
    w_enter      = (r_state == ST_SCAN) && !r_valid;
    w_accept     = r_valid && i_scan_ready;
    w_last       = w_accept && (r_pos == LAST8);
    w_busy       = (r_state != ST_LOAD) || r_pend || !w_pipe_empty;
    w_wr_char    = (i_space || i_unassigned) ? '0 : i_bcd;
    // The next scan character is fetched one position ahead so it is registered on acceptance.
    w_rd_pos     = w_enter ? '0 : r_pos + 8'd1;
    w_rd_char    = (w_rd_pos < r_count) ? r_buf[w_rd_pos] : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pipe  <= '0;
      r_pend  <= 1'b0;
      r_count <= '0;
      r_dc    <= 1'b0;
      r_ov    <= 1'b0;
      r_valid <= 1'b0;
      r_pos   <= '0;
      r_char  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_pipe  <= '0;
        r_pend  <= 1'b0;
        r_count <= '0;
        r_dc    <= 1'b0;
        r_ov    <= 1'b0;
        r_valid <= 1'b0;
        r_pos   <= '0;
        r_char  <= '0;
      end else begin
        r_pipe <= (r_pipe << 1) | CONV_LAT'(i_strobe);
        if (w_load) begin
          r_count <= r_count + 8'd1;
          if (i_unassigned) r_dc <= 1'b1;
        end else if (w_aligned) begin
          r_ov <= 1'b1;
        end
        if (r_state == ST_LOAD) begin
          if (r_pend && w_pipe_empty) r_pend <= 1'b0;
          else if (i_print)           r_pend <= 1'b1;
        end
        if (w_enter) begin
          r_valid <= 1'b1;
          r_pos   <= '0;
          r_char  <= w_rd_char;
        end else if (w_last) begin
          r_valid <= 1'b0;
          r_pos   <= '0;
          r_char  <= '0;
          r_done  <= 1'b1;
          r_count <= '0;
        end else if (w_accept) begin
          r_pos  <= w_rd_pos;
          r_char <= w_rd_char;
        end
      end
    end
  end

  // Line storage is never erased; r_count alone decides which positions are visible.
  always_ff @(posedge i_clk) begin
    if (w_load && !i_reset && !i_clear) r_buf[r_count] <= w_wr_char;
  end

`ifdef BCD_PARITY_EN
  logic r_par;
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)          r_par <= 1'b0;
    else if (w_enter)                r_par <= ~^w_rd_char;
    else if (w_last)                 r_par <= 1'b0;
    else if (w_accept)               r_par <= ~^w_rd_char;
  end
  assign o_scan_parity = r_par;
`else
  assign o_scan_parity = 1'b0;
`endif

  assign o_scan_valid = r_valid;
  assign o_scan_pos   = r_pos;
  assign o_scan_char  = r_char;
  assign o_print_done = r_done;
  assign o_count      = r_count;
  assign o_full       = (r_count == LEN8);
  assign o_busy       = w_busy;
  assign o_data_check = r_dc;
  assign o_overrun    = r_ov;

endmodule

// File: tb/tb_bcd_line_buf.sv
// Self-checking bench for bcd_line_buf: queue-based converter emulation plus a line-level reference model.
module tb_bcd_line_buf;
  localparam int LINE_LEN = 132;
  localparam int CONV_LAT = 3;

  logic       i_clk, i_reset, i_strobe, i_space, i_unassigned, i_print, i_clear, i_scan_ready;
  logic [5:0] i_bcd;
  logic       o_scan_valid, o_scan_parity, o_print_done, o_full, o_busy, o_data_check, o_overrun;
  logic [7:0] o_scan_pos, o_count;
  logic [5:0] o_scan_char;

  bcd_line_buf #(.LINE_LEN(LINE_LEN), .CONV_LAT(CONV_LAT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_strobe(i_strobe), .i_bcd(i_bcd),
    .i_space(i_space), .i_unassigned(i_unassigned), .i_print(i_print), .i_clear(i_clear),
    .i_scan_ready(i_scan_ready), .o_scan_valid(o_scan_valid), .o_scan_pos(o_scan_pos),
    .o_scan_char(o_scan_char), .o_scan_parity(o_scan_parity), .o_print_done(o_print_done),
    .o_count(o_count), .o_full(o_full), .o_busy(o_busy), .o_data_check(o_data_check),
    .o_overrun(o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [5:0] bcd;
    logic       sp;
    logic       un;
  } conv_t;

  conv_t      q[$];
  logic [5:0] m_line [LINE_LEN];
  int         m_cnt, m_pos, cyc, dut_done, done_cyc;
  bit         m_dc, m_ov, m_pend, m_scan, m_valid, m_done;
  logic [5:0] cap[$];
  logic       capp[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_char(input int p);
    return (p < m_cnt) ? m_line[p] : 6'o00;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_dc = 0; m_ov = 0; m_pend = 0; m_scan = 0; m_valid = 0; m_done = 0;
    q.delete();
  endtask

  // One clock: drive inputs at negedge, check outputs against the model, then advance the model.
  task automatic step(input logic str, input logic [5:0] bcd, input logic sp, input logic un,
                      input logic prt, input logic clr, input logic rdy);
    logic  a;
    bit    empty;
    conv_t e;
    logic  exp_par;
    @(negedge i_clk);
    i_strobe = str; i_print = prt; i_clear = clr; i_scan_ready = rdy;
    a = (q.size() > 0) && (q[0].due == cyc);
    if (a) begin
      i_bcd = q[0].bcd; i_space = q[0].sp; i_unassigned = q[0].un;
    end else begin
      i_bcd = 6'($urandom); i_space = 1'($urandom); i_unassigned = 1'($urandom);
    end
    empty = (q.size() == 0);

    chk("count", 32'(o_count), 32'(m_cnt));
    chk("full", 32'(o_full), 32'(m_cnt == LINE_LEN));
    chk("busy", 32'(o_busy), 32'(m_scan || m_pend || !empty));
    chk("data_check", 32'(o_data_check), 32'(m_dc));
    chk("overrun", 32'(o_overrun), 32'(m_ov));
    chk("scan_valid", 32'(o_scan_valid), 32'(m_valid));
    chk("print_done", 32'(o_print_done), 32'(m_done));
    if (m_valid) begin
`ifdef BCD_PARITY_EN
      exp_par = ~^exp_char(m_pos);
`else
      exp_par = 1'b0;
`endif
      chk("scan_pos", 32'(o_scan_pos), 32'(m_pos));
      chk("scan_char", 32'(o_scan_char), 32'(exp_char(m_pos)));
      chk("scan_parity", 32'(o_scan_parity), 32'(exp_par));
    end
    if (o_print_done === 1'b1) begin
      dut_done++;
      done_cyc = cyc;
    end
    if (o_scan_valid === 1'b1 && rdy) begin
      cap.push_back(o_scan_char);
      capp.push_back(o_scan_parity);
    end

    m_done = 0;
    if (clr) begin
      m_scan = 0; m_pend = 0; m_cnt = 0; m_dc = 0; m_ov = 0; m_valid = 0;
      q.delete();
    end else begin
      if (a) begin
        if (!m_scan && m_cnt < LINE_LEN) begin
          m_line[m_cnt] = (q[0].sp || q[0].un) ? 6'o00 : q[0].bcd;
          if (q[0].un) m_dc = 1;
          m_cnt++;
        end else begin
          m_ov = 1;
        end
        q.delete(0);
      end
      if (m_scan) begin
        if (!m_valid) begin
          m_valid = 1; m_pos = 0;
        end else if (rdy) begin
          if (m_pos == LINE_LEN - 1) begin
            m_valid = 0; m_scan = 0; m_done = 1; m_cnt = 0;
          end else begin
            m_pos++;
          end
        end
      end else if (m_pend && empty) begin
        m_scan = 1; m_pend = 0;
      end else if (prt) begin
        m_pend = 1;
      end
      if (str) begin
        e.due = cyc + CONV_LAT; e.bcd = bcd; e.sp = sp; e.un = un;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 6'o00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic [5:0] bcd, input logic sp, input logic un);
    step(1'b1, bcd, sp, un, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: always ready, 1: ready toggles every cycle, 2: random ready; inj: loop index that strobes
  task automatic run_scan(input int mode, input int inj);
    int   k;
    logic rdy;
    cap.delete(); capp.delete();
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (k = 0; k < 2000 && (m_scan || m_pend); k++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(k & 1) : 1'($urandom);
      step(1'(k == inj), 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    end
    if (m_scan || m_pend) chk("scan_timeout", 32'(1), 32'(0));
    idle(CONV_LAT + 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    i_reset = 1'b1; i_strobe = 1'b0; i_print = 1'b0; i_clear = 1'b0; i_scan_ready = 1'b0;
    i_bcd = '0; i_space = 1'b0; i_unassigned = 1'b0;
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("rst_count", 32'(o_count), 32'(0));
    chk("rst_full", 32'(o_full), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_flags", 32'({o_data_check, o_overrun}), 32'(0));
    chk("rst_scan", 32'({o_scan_valid, o_scan_pos, o_scan_char, o_scan_parity}), 32'(0));
    chk("rst_done", 32'(o_print_done), 32'(0));
    model_reset();
  endtask

  initial begin
    int start, n, base;
    i_reset = 1'b0; i_strobe = 1'b0; i_print = 1'b0; i_clear = 1'b0; i_scan_ready = 1'b0;
    i_bcd = '0; i_space = 1'b0; i_unassigned = 1'b0;
    cyc = 0; dut_done = 0; done_cyc = 0;
    model_reset();
    do_reset(2);

    // Three characters through the alignment pipe.
    strobe(6'o61, 1'b0, 1'b0);
    strobe(6'o12, 1'b0, 1'b0);
    strobe(6'o01, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    chk("busy_inflight", 32'(o_busy), 32'(1));
    idle(5);
    chk("count3", 32'(o_count), 32'(3));
    chk("idle_busy", 32'(o_busy), 32'(0));

    start = cyc;
    run_scan(0, -1);
    chk("cap_len", 32'(cap.size()), 32'(LINE_LEN));
    chk("cap0", 32'(cap[0]), 32'(6'o61));
    chk("cap1", 32'(cap[1]), 32'(6'o12));
    chk("cap2", 32'(cap[2]), 32'(6'o01));
    n = 0;
    for (int i = 3; i < cap.size(); i++) if (cap[i] != 6'o00) n++;
    chk("cap_blank", 32'(n), 32'(0));
    chk("done_once", 32'(dut_done), 32'(1));
    chk("done_latency", 32'(done_cyc - start >= LINE_LEN + 1), 32'(1));
    chk("count_after", 32'(o_count), 32'(0));
`ifdef BCD_PARITY_EN
    chk("par61", 32'(capp[0]), 32'(0));
    chk("par12", 32'(capp[1]), 32'(1));
`endif

    // Space and unassigned both print blank; data check sticks through the scan.
    strobe(6'o25, 1'b1, 1'b0);
    strobe(6'o77, 1'b0, 1'b1);
    idle(5);
    chk("dc_set", 32'(o_data_check), 32'(1));
    run_scan(0, -1);
    chk("dc_kept", 32'(o_data_check), 32'(1));
    chk("space_blank", 32'(cap[0]), 32'(6'o00));
    chk("unas_blank", 32'(cap[1]), 32'(6'o00));

    // Fill to capacity, then one over.
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < LINE_LEN; i++) strobe(6'($urandom), 1'b0, 1'b0);
    idle(5);
    chk("full_132", 32'(o_full), 32'(1));
    chk("no_ov_132", 32'(o_overrun), 32'(0));
    strobe(6'o33, 1'b0, 1'b0);
    idle(5);
    chk("ov_133", 32'(o_overrun), 32'(1));
    chk("count_132", 32'(o_count), 32'(LINE_LEN));
    run_scan(1, -1);

    // Print one cycle after a strobe; a strobe during the scan overruns.
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe(6'o45, 1'b0, 1'b0);
    run_scan(2, 30);
    chk("late_char", 32'(cap[0]), 32'(6'o45));
    chk("scan_ov", 32'(o_overrun), 32'(1));

    // Clear in the middle of a scan.
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe(6'o11, 1'b0, 1'b1);
    strobe(6'o22, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'(k == 5), 6'o07, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    base = dut_done;
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("clr_count", 32'(o_count), 32'(0));
    chk("clr_flags", 32'({o_data_check, o_overrun}), 32'(0));
    chk("clr_valid", 32'(o_scan_valid), 32'(0));
    chk("clr_nodone", 32'(dut_done), 32'(base));

    // Randomized lines.
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 6'o00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n = $urandom_range(0, 140);
      for (int i = 0; i < n; i++) begin
        strobe(6'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        idle($urandom_range(0, 2));
      end
      run_scan(2, (r % 2 == 0) ? int'($urandom_range(0, 100)) : -1);
    end

    // Reset while scanning.
    strobe(6'o52, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 6'o00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 6'o00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
